// File: rtl/unfunnel_gather.sv
// unfunnel_gather: assembles narrow per-lane chunks over several beats into one wide word
// Optional feature macro: UNFUNNEL_GATHER_FLUSH_EN (adds t_last, early word completion)
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   cfg_req/cfg_ack     config handshake; cfg_mode selects lanes per beat (one-hot, <= LANES)
//   cfg_err             sticky illegal-mode flag
//   t_req/t_ack/t_data  per-lane chunk inputs, all-or-none acceptance over active lanes
//   t_last              (flush build only) completes the word on this beat
//   i_0_req/ack/data    wide output word, held until acknowledged
module unfunnel_gather #(
    parameter int CHUNK_W = 128,
    parameter int LANES   = 4,
    parameter int CHUNKS  = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cfg_req,
    output logic                        cfg_ack,
    input  logic [7:0]                  cfg_mode,
    output logic                        cfg_err,
`ifdef UNFUNNEL_GATHER_FLUSH_EN
    input  logic                        t_last,
`endif
    input  logic [LANES-1:0]            t_req,
    output logic [LANES-1:0]            t_ack,
    input  logic [LANES*CHUNK_W-1:0]    t_data,
    output logic                        i_0_req,
    input  logic                        i_0_ack,
    output logic [CHUNKS*CHUNK_W-1:0]   i_0_data
);
    localparam int STEPS = $clog2(CHUNKS);
    logic [STEPS-1:0]          cnt, r, next_cnt;
    logic [STEPS-1:0]          slot [LANES];
    logic [LANES-1:0]          active;
    logic [CHUNKS*CHUNK_W-1:0] asm_q, merged;
    logic                      out_valid, cfg_fire, legal, last, fire;
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign active[g] = r > STEPS'(g);
        assign slot[g]   = cnt + STEPS'(g);
    end
    assign next_cnt = cnt + r;
`ifdef UNFUNNEL_GATHER_FLUSH_EN
    assign last = (next_cnt == '0) | t_last;
`else
    assign last = next_cnt == '0;
`endif
    assign cfg_ack  = (cnt == '0) && !out_valid;
    assign cfg_fire = cfg_req && cfg_ack;
    // mode is judged on all 8 bits so stray upper bits count as illegal
    assign legal    = $onehot(cfg_mode) && (cfg_mode <= 8'(LANES));
    // a last beat may only fire when the output register is free or draining now
    assign fire     = (&(t_req | ~active)) && (!last || !out_valid || i_0_ack) && !cfg_fire;
    assign t_ack    = active & {LANES{fire}};
    assign i_0_req  = out_valid;
    // current beat merged over the buffer, so the last beat's chunks reach the output directly
    always_comb begin
        merged = asm_q;
        for (int j = 0; j < LANES; j++)
            if (active[j]) merged[slot[j]*CHUNK_W +: CHUNK_W] = t_data[j*CHUNK_W +: CHUNK_W];
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt       <= '0;
            r         <= STEPS'(LANES);
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
            asm_q     <= '0;
            i_0_data  <= '0;
        end else begin
            if (cfg_fire && legal) r <= cfg_mode[STEPS-1:0];
            if (cfg_fire && !legal) cfg_err <= 1'b1;
            // buffer clears at word end so a flushed word reads unwritten slots as zero
            if (fire) begin
                cnt   <= last ? '0 : next_cnt;
                asm_q <= last ? '0 : merged;
            end
            if (fire && last) begin
                i_0_data  <= merged;
                out_valid <= 1'b1;
            end else if (i_0_ack) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_unfunnel_gather.sv
// tb_unfunnel_gather: scoreboard bench for unfunnel_gather with directed vectors
module tb_unfunnel_gather;
    localparam int CW = 128;
    localparam int L  = 4;
    localparam int C  = 8;
    typedef logic [C*CW-1:0] word_t;
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_req = 1'b0;
    logic          cfg_ack;
    logic [7:0]    cfg_mode = 8'd0;
    logic          cfg_err;
    logic [L-1:0]  t_req = '0;
    logic [L-1:0]  t_ack;
    logic [L*CW-1:0] t_data = '0;
    logic          i_0_req;
    logic          i_0_ack = 1'b0;
    word_t         i_0_data;
`ifdef UNFUNNEL_GATHER_FLUSH_EN
    logic          t_last = 1'b0;
`endif
    int            vecs = 0;
    int            errs = 0;
    word_t         exp_q [$];

    unfunnel_gather #(.CHUNK_W(CW), .LANES(L), .CHUNKS(C)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_req(cfg_req), .cfg_ack(cfg_ack), .cfg_mode(cfg_mode), .cfg_err(cfg_err),
`ifdef UNFUNNEL_GATHER_FLUSH_EN
        .t_last(t_last),
`endif
        .t_req(t_req), .t_ack(t_ack), .t_data(t_data),
        .i_0_req(i_0_req), .i_0_ack(i_0_ack), .i_0_data(i_0_data)
    );

    always #5 clk = ~clk;

    // slots 0..n-1 hold base+s, remaining slots zero
    function automatic word_t seq(input int base, input int n);
        word_t w = '0;
        for (int s = 0; s < n; s++) w[s*CW +: CW] = CW'(base + s);
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [L-1:0] req, input int base);
        t_req = req;
        for (int j = 0; j < L; j++) t_data[j*CW +: CW] = CW'(base + j);
    endtask

    task automatic beat(input string name, input logic [L-1:0] req, input int base, input logic [L-1:0] exp);
        drive(req, base);
        @(negedge clk);
        chk(name, t_ack, exp);
        @(posedge clk); #1;
        t_req = '0;
    endtask

    task automatic cfg(input string name, input logic [7:0] mode, input logic exp);
        cfg_mode = mode;
        cfg_req  = 1'b1;
        @(negedge clk);
        chk(name, cfg_ack, exp);
        @(posedge clk); #1;
        cfg_req = 1'b0;
    endtask

    // monitor: every output handshake pops one expected word
    always @(negedge clk) begin
        if (reset_n && i_0_req && i_0_ack) begin
            word_t e;
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL word_unexpected: got word slot0 %0h expected no word", i_0_data[CW-1:0]);
            end else begin
                e = exp_q.pop_front();
                if (i_0_data !== e) begin
                    errs++;
                    for (int s = 0; s < C; s++)
                        if (i_0_data[s*CW +: CW] !== e[s*CW +: CW]) begin
                            $display("FAIL word_slot%0d: got %0h expected %0h", s, i_0_data[s*CW +: CW], e[s*CW +: CW]);
                            break;
                        end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_i0_req", i_0_req, 0);
        chk("rst_t_ack", t_ack, 0);
        chk("rst_cfg_ack", cfg_ack, 1);
        chk("rst_cfg_err", cfg_err, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        // R=4 default, two beats complete a word, req high exactly one cycle
        i_0_ack = 1'b1;
        exp_q.push_back(seq(0, 8));
        beat("r4_b0", 4'hF, 0, 4'hF);
        beat("r4_b1", 4'hF, 4, 4'hF);
        @(negedge clk);
        chk("r4_req_on", i_0_req, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("r4_req_off", i_0_req, 0);
        @(posedge clk); #1;
        // R=1, all lanes requesting, only lane 0 accepted
        cfg("cfg_r1", 8'h01, 1);
        exp_q.push_back(seq('hA0, 8));
        for (int i = 0; i < 8; i++) beat("r1_beat", 4'hF, 'hA0 + i, 4'h1);
        @(negedge clk);
        chk("r1_req", i_0_req, 1);
        @(posedge clk); #1;
        // R=2 with back-pressure: last beat of word B waits for word A to drain
        cfg("cfg_r2", 8'h02, 1);
        i_0_ack = 1'b0;
        exp_q.push_back(seq('h10, 8));
        for (int i = 0; i < 4; i++) beat("r2_a", 4'h3, 'h10 + 2*i, 4'h3);
        exp_q.push_back(seq('h20, 8));
        for (int i = 0; i < 3; i++) beat("r2_b", 4'h3, 'h20 + 2*i, 4'h3);
        drive(4'h3, 'h26);
        repeat (2) begin
            @(negedge clk);
            chk("r2_stall", t_ack, 0);
            chk("r2_hold_req", i_0_req, 1);
            chk("r2_hold_data", i_0_data == seq('h10, 8), 1);
            @(posedge clk); #1;
        end
        i_0_ack = 1'b1;
        @(negedge clk);
        chk("r2_drain_load", t_ack, 4'h3);
        @(posedge clk); #1;
        t_req = '0;
        @(negedge clk);
        chk("r2_second_req", i_0_req, 1);
        @(posedge clk); #1;
        // R=4, one lane missing blocks the whole beat
        cfg("cfg_r4", 8'h04, 1);
        drive(4'hB, 'h40);
        repeat (2) begin
            @(negedge clk);
            chk("r4_lane2_low", t_ack, 0);
            @(posedge clk); #1;
        end
        exp_q.push_back(seq('h40, 8));
        beat("r4_lane2_up", 4'hF, 'h40, 4'hF);
        beat("r4_b1b", 4'hF, 'h44, 4'hF);
        @(negedge clk);
        @(posedge clk); #1;
        // illegal mode keeps R=4 and sets the sticky error
        cfg("cfg_bad", 8'h03, 1);
        chk("cfg_err_set", cfg_err, 1);
        exp_q.push_back(seq('h50, 8));
        beat("r4_after_bad", 4'hF, 'h50, 4'hF);
        cfg_mode = 8'h04;
        cfg_req  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("cfg_mid_word", cfg_ack, 0);
            @(posedge clk); #1;
        end
        drive(4'hF, 'h54);
        @(negedge clk);
        chk("cfg_mid_beat", t_ack, 4'hF);
        @(posedge clk); #1;
        t_req = '0;
        @(negedge clk);
        chk("cfg_out_pending", cfg_ack, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cfg_drained", cfg_ack, 1);
        @(posedge clk); #1;
        cfg_req = 1'b0;
        chk("cfg_err_sticky", cfg_err, 1);
        // reset with a pending word and a half-built word discards both
        i_0_ack = 1'b0;
        beat("pre_rst_a0", 4'hF, 'h60, 4'hF);
        beat("pre_rst_a1", 4'hF, 'h64, 4'hF);
        beat("pre_rst_b0", 4'hF, 'h68, 4'hF);
        @(negedge clk);
        chk("pre_rst_req", i_0_req, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req", i_0_req, 0);
        chk("post_rst_cfg_ack", cfg_ack, 1);
        chk("post_rst_err", cfg_err, 0);
        @(posedge clk); #1;
        i_0_ack = 1'b1;
        exp_q.push_back(seq('h70, 8));
        beat("post_rst_b0", 4'hF, 'h70, 4'hF);
        beat("post_rst_b1", 4'hF, 'h74, 4'hF);
        @(negedge clk);
        chk("post_rst_word", i_0_req, 1);
        @(posedge clk); #1;
`ifdef UNFUNNEL_GATHER_FLUSH_EN
        // early completion: slots 3..7 read as zero
        cfg("cfg_r1_flush", 8'h01, 1);
        exp_q.push_back(seq('h30, 3));
        beat("flush_b0", 4'h1, 'h30, 4'h1);
        beat("flush_b1", 4'h1, 'h31, 4'h1);
        t_last = 1'b1;
        beat("flush_b2", 4'h1, 'h32, 4'h1);
        t_last = 1'b0;
        @(negedge clk);
        chk("flush_req", i_0_req, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_cfg_ack", cfg_ack, 1);
        @(posedge clk); #1;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
